// File: rtl/fractal_dispatcher.sv
// Frame scheduler: walks the pixel grid, hands pixels to free fractal cores and streams tagged results.
// Optional perf counters are enabled by defining FRACTAL_DISPATCH_PERF_EN.
module fractal_dispatcher #(
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int CORE_COUNT      = 2,
  parameter int COORD_WIDTH     = 12,
  localparam int DATA_WIDTH     = INTEGER_BITS + FRACTIONAL_BITS
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       start_i,
  input  logic [DATA_WIDTH-1:0]                      x_start_i,
  input  logic [DATA_WIDTH-1:0]                      y_start_i,
  input  logic [DATA_WIDTH-1:0]                      step_i,
  input  logic [COORD_WIDTH-1:0]                     width_i,
  input  logic [COORD_WIDTH-1:0]                     height_i,
  input  logic [MAX_ITER_WIDTH-1:0]                  max_iter_i,
  output logic [CORE_COUNT-1:0]                      core_rst_o,
  output logic [CORE_COUNT-1:0]                      core_start_o,
  output logic [CORE_COUNT-1:0][DATA_WIDTH-1:0]      core_x0_o,
  output logic [CORE_COUNT-1:0][DATA_WIDTH-1:0]      core_y0_o,
  output logic [MAX_ITER_WIDTH-1:0]                  core_max_iter_o,
  input  logic [CORE_COUNT-1:0][MAX_ITER_WIDTH-1:0]  core_iter_i,
  input  logic [CORE_COUNT-1:0]                      core_done_i,
  output logic                                       res_valid_o,
  input  logic                                       res_ready_i,
  output logic [COORD_WIDTH-1:0]                     res_col_o,
  output logic [COORD_WIDTH-1:0]                     res_row_o,
  output logic [MAX_ITER_WIDTH-1:0]                  res_iter_o,
  output logic                                       busy_o,
`ifdef FRACTAL_DISPATCH_PERF_EN
  output logic                                       frame_done_o,
  output logic [31:0]                                perf_cycles_o,
  output logic [31:0]                                perf_stall_o
`else
  output logic                                       frame_done_o
`endif
);

  localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} top_e;
  typedef enum logic [1:0] {SL_FREE, SL_RUN, SL_DONE_W, SL_CLR} slot_e;

  top_e                      state_q, state_d;
  logic [DATA_WIDTH-1:0]     x_start_q, x_start_d, step_q, step_d;
  logic [DATA_WIDTH-1:0]     x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [COORD_WIDTH-1:0]    width_q, width_d, height_q, height_d;
  logic [COORD_WIDTH-1:0]    col_q, col_d, row_q, row_d;
  logic [MAX_ITER_WIDTH-1:0] max_iter_q, max_iter_d;

  slot_e                     slot_q [CORE_COUNT];
  slot_e                     slot_d [CORE_COUNT];
  logic [COORD_WIDTH-1:0]    tag_col_q [CORE_COUNT];
  logic [COORD_WIDTH-1:0]    tag_col_d [CORE_COUNT];
  logic [COORD_WIDTH-1:0]    tag_row_q [CORE_COUNT];
  logic [COORD_WIDTH-1:0]    tag_row_d [CORE_COUNT];
  logic [MAX_ITER_WIDTH-1:0] iter_q [CORE_COUNT];
  logic [MAX_ITER_WIDTH-1:0] iter_d [CORE_COUNT];
  logic [DATA_WIDTH-1:0]     x0_q [CORE_COUNT];
  logic [DATA_WIDTH-1:0]     x0_d [CORE_COUNT];
  logic [DATA_WIDTH-1:0]     y0_q [CORE_COUNT];
  logic [DATA_WIDTH-1:0]     y0_d [CORE_COUNT];

  logic                      res_valid_q, res_valid_d;
  logic [COORD_WIDTH-1:0]    res_col_q, res_col_d, res_row_q, res_row_d;
  logic [MAX_ITER_WIDTH-1:0] res_iter_q, res_iter_d;
  logic [IDX_W-1:0]          rr_last_q, rr_last_d;
  logic                      busy_q, busy_d, frame_done_q, frame_done_d;

  logic                      disp_any, gnt_any, load_en, all_free;
  logic [IDX_W-1:0]          disp_idx, gnt_idx;

  always_comb begin
    state_d    = state_q;
    x_start_d  = x_start_q;
    step_d     = step_q;
    x_acc_d    = x_acc_q;
    y_acc_d    = y_acc_q;
    width_d    = width_q;
    height_d   = height_q;
    col_d      = col_q;
    row_d      = row_q;
    max_iter_d = max_iter_q;
    slot_d     = slot_q;
    tag_col_d  = tag_col_q;
    tag_row_d  = tag_row_q;
    iter_d     = iter_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    res_valid_d = res_valid_q;
    res_col_d  = res_col_q;
    res_row_d  = res_row_q;
    res_iter_d = res_iter_q;
    rr_last_d  = rr_last_q;
    core_start_o = '0;
    core_rst_o   = {CORE_COUNT{rst_i}};
    disp_any = 1'b0;
    disp_idx = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    all_free = 1'b1;
    load_en  = !res_valid_q || res_ready_i;

    for (int k = 0; k < CORE_COUNT; k++) begin
      if (!disp_any && !rst_i && state_q == ST_RUN && slot_q[k] == SL_FREE) begin
        disp_any = 1'b1;
        disp_idx = IDX_W'(k);
      end
    end

    // Round-robin: search above the last grant first, then wrap around.
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (!gnt_any && load_en && k > int'(rr_last_q) && slot_q[k] == SL_DONE_W) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (!gnt_any && load_en && k <= int'(rr_last_q) && slot_q[k] == SL_DONE_W) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end

    for (int k = 0; k < CORE_COUNT; k++) begin
      all_free = all_free && (slot_q[k] == SL_FREE);
      case (slot_q[k])
        SL_FREE: if (disp_any && disp_idx == IDX_W'(k)) begin
          slot_d[k]       = SL_RUN;
          tag_col_d[k]    = col_q;
          tag_row_d[k]    = row_q;
          x0_d[k]         = x_acc_q;
          y0_d[k]         = y_acc_q;
          core_start_o[k] = 1'b1;
        end
        SL_RUN: if (core_done_i[k]) begin
          slot_d[k] = SL_DONE_W;
          iter_d[k] = core_iter_i[k];
        end
        SL_DONE_W: if (gnt_any && gnt_idx == IDX_W'(k)) slot_d[k] = SL_CLR;
        default: begin
          slot_d[k]     = SL_FREE;
          core_rst_o[k] = 1'b1;
        end
      endcase
      // Coordinates reach the core in the same cycle as its start pulse.
      core_x0_o[k] = x0_d[k];
      core_y0_o[k] = y0_d[k];
    end

    if (gnt_any) begin
      res_valid_d = 1'b1;
      res_col_d   = tag_col_q[gnt_idx];
      res_row_d   = tag_row_q[gnt_idx];
      res_iter_d  = iter_q[gnt_idx];
      rr_last_d   = gnt_idx;
    end else if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: if (start_i) begin
        x_start_d  = x_start_i;
        step_d     = step_i;
        width_d    = width_i;
        height_d   = height_i;
        max_iter_d = max_iter_i;
        x_acc_d    = x_start_i;
        y_acc_d    = y_start_i;
        col_d      = '0;
        row_d      = '0;
        state_d    = (width_i == '0 || height_i == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: if (disp_any) begin
        if (col_q == width_q - COORD_WIDTH'(1)) begin
          col_d   = '0;
          x_acc_d = x_start_q;
          if (row_q == height_q - COORD_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            row_d   = row_q + COORD_WIDTH'(1);
            y_acc_d = y_acc_q + step_q;
          end
        end else begin
          col_d   = col_q + COORD_WIDTH'(1);
          x_acc_d = x_acc_q + step_q;
        end
      end
      ST_DRAIN: if (all_free && !res_valid_q) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      x_start_q    <= '0;
      step_q       <= '0;
      x_acc_q      <= '0;
      y_acc_q      <= '0;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      max_iter_q   <= '0;
      for (int k = 0; k < CORE_COUNT; k++) begin
        slot_q[k]    <= SL_FREE;
        tag_col_q[k] <= '0;
        tag_row_q[k] <= '0;
        iter_q[k]    <= '0;
        x0_q[k]      <= '0;
        y0_q[k]      <= '0;
      end
      res_valid_q  <= 1'b0;
      res_col_q    <= '0;
      res_row_q    <= '0;
      res_iter_q   <= '0;
      rr_last_q    <= IDX_W'(CORE_COUNT - 1);
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_start_q    <= x_start_d;
      step_q       <= step_d;
      x_acc_q      <= x_acc_d;
      y_acc_q      <= y_acc_d;
      width_q      <= width_d;
      height_q     <= height_d;
      col_q        <= col_d;
      row_q        <= row_d;
      max_iter_q   <= max_iter_d;
      slot_q       <= slot_d;
      tag_col_q    <= tag_col_d;
      tag_row_q    <= tag_row_d;
      iter_q       <= iter_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      res_valid_q  <= res_valid_d;
      res_col_q    <= res_col_d;
      res_row_q    <= res_row_d;
      res_iter_q   <= res_iter_d;
      rr_last_q    <= rr_last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign core_max_iter_o = max_iter_q;
  assign res_valid_o     = res_valid_q;
  assign res_col_o       = res_col_q;
  assign res_row_o       = res_row_q;
  assign res_iter_o      = res_iter_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = frame_done_q;

`ifdef FRACTAL_DISPATCH_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stall_q, perf_stall_d;
  logic        any_done_w;

  always_comb begin
    any_done_w = 1'b0;
    for (int k = 0; k < CORE_COUNT; k++) any_done_w = any_done_w || (slot_q[k] == SL_DONE_W);
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (state_q == ST_IDLE && start_i) begin
      perf_cycles_d = 32'd1;
      perf_stall_d  = '0;
    end else begin
      if (state_q != ST_IDLE) perf_cycles_d = perf_cycles_q + 32'd1;
      if (any_done_w && res_valid_q && !res_ready_i) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_fractal_dispatcher.sv
// Directed bench for fractal_dispatcher with behavioural stub cores and a result monitor.
module tb_fractal_dispatcher;
  localparam int DW = 32;
  localparam int MW = 16;
  localparam int CC = 2;
  localparam int CW = 12;

  logic                   clk_i = 1'b0;
  logic                   rst_i, start_i, res_ready_i;
  logic [DW-1:0]          x_start_i, y_start_i, step_i;
  logic [CW-1:0]          width_i, height_i;
  logic [MW-1:0]          max_iter_i;
  logic [CC-1:0]          core_rst_o, core_start_o;
  logic [CC-1:0][DW-1:0]  core_x0_o, core_y0_o;
  logic [MW-1:0]          core_max_iter_o;
  logic [CC-1:0][MW-1:0]  core_iter_i;
  logic [CC-1:0]          core_done_i;
  logic                   res_valid_o, busy_o, frame_done_o;
  logic [CW-1:0]          res_col_o, res_row_o;
  logic [MW-1:0]          res_iter_o;
`ifdef FRACTAL_DISPATCH_PERF_EN
  logic [31:0]            perf_cycles_o, perf_stall_o;
`endif

  fractal_dispatcher dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .x_start_i(x_start_i), .y_start_i(y_start_i), .step_i(step_i),
    .width_i(width_i), .height_i(height_i), .max_iter_i(max_iter_i),
    .core_rst_o(core_rst_o), .core_start_o(core_start_o),
    .core_x0_o(core_x0_o), .core_y0_o(core_y0_o), .core_max_iter_o(core_max_iter_o),
    .core_iter_i(core_iter_i), .core_done_i(core_done_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_col_o(res_col_o), .res_row_o(res_row_o), .res_iter_o(res_iter_o),
    .busy_o(busy_o),
`ifdef FRACTAL_DISPATCH_PERF_EN
    .perf_cycles_o(perf_cycles_o), .perf_stall_o(perf_stall_o),
`endif
    .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [MW-1:0] hash(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return x[31:16] ^ x[15:0] ^ y[30:15];
  endfunction

  // Stub cores: done 'lat' cycles after start, result held until reset.
  int            lat [CC];
  int            cnt [CC];
  logic          run_s [CC];
  int            starts_per [CC];
  int            rsts_per [CC];
  logic [DW-1:0] start_x [$];
  logic [DW-1:0] start_y [$];

  initial begin
    core_done_i = '0;
    core_iter_i = '0;
    for (int k = 0; k < CC; k++) begin
      run_s[k] = 1'b0; cnt[k] = 0; starts_per[k] = 0; rsts_per[k] = 0;
    end
    forever begin
      @(negedge clk_i);
      for (int k = 0; k < CC; k++) begin
        if (core_rst_o[k]) begin
          core_done_i[k] = 1'b0;
          run_s[k] = 1'b0;
          if (!rst_i) rsts_per[k]++;
        end else if (core_start_o[k]) begin
          run_s[k] = 1'b1;
          cnt[k] = lat[k];
          start_x.push_back(core_x0_o[k]);
          start_y.push_back(core_y0_o[k]);
          starts_per[k]++;
          core_iter_i[k] = hash(core_x0_o[k], core_y0_o[k]);
        end else if (run_s[k]) begin
          cnt[k]--;
          if (cnt[k] <= 0) begin
            core_done_i[k] = 1'b1;
            run_s[k] = 1'b0;
          end
        end
      end
    end
  end

  int            cyc = 0;
  int            done_cnt = 0;
  logic [CW-1:0] r_col [$];
  logic [CW-1:0] r_row [$];
  logic [MW-1:0] r_iter [$];
  int            r_cyc [$];

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    #2;
    if (res_valid_o && res_ready_i) begin
      r_col.push_back(res_col_o);
      r_row.push_back(res_row_o);
      r_iter.push_back(res_iter_o);
      r_cyc.push_back(cyc);
    end
    if (frame_done_o) done_cnt++;
  end

  task automatic drive_start(input logic [DW-1:0] xs, input logic [DW-1:0] ys, input logic [DW-1:0] st,
                             input int w, input int h);
    @(negedge clk_i);
    x_start_i = xs; y_start_i = ys; step_i = st;
    width_i = CW'(w); height_i = CW'(h); max_iter_i = 16'd100;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_frame(input int db, input string tag);
    int n = 0;
    while (done_cnt == db && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    repeat (4) @(negedge clk_i);
    chk(tag, done_cnt - db, 1);
  endtask

  task automatic check_frame(input int sb, input int rb, input logic [DW-1:0] xs, input logic [DW-1:0] ys,
                             input logic [DW-1:0] st, input int w, input int h, input string tag);
    int n = w * h;
    logic [63:0] mask = '0;
    chk({tag, "_nstart"}, start_x.size() - sb, n);
    chk({tag, "_nres"}, r_col.size() - rb, n);
    for (int i = 0; i < n; i++) begin
      if (sb + i < start_x.size()) begin
        chk({tag, "_x0"}, start_x[sb+i], 32'(xs + 32'(i % w) * st));
        chk({tag, "_y0"}, start_y[sb+i], 32'(ys + 32'(i / w) * st));
      end
    end
    for (int i = rb; i < r_col.size(); i++) begin
      int c = int'(r_col[i]);
      int r = int'(r_row[i]);
      chk({tag, "_iter"}, r_iter[i], hash(32'(xs + 32'(c) * st), 32'(ys + 32'(r) * st)));
      mask[(r * w + c) % 64] = 1'b1;
    end
    chk({tag, "_cover"}, mask, (64'd1 << n) - 64'd1);
  endtask

  int sb, rb, db, s0, s1, q0, q1, unstable, n;
  logic [CW-1:0] snap_col, snap_row;
  logic [MW-1:0] snap_iter;
  logic [DW-1:0] exp_x [4];
  logic [DW-1:0] exp_y [4];

  initial begin
    rst_i = 1'b1; start_i = 1'b0; res_ready_i = 1'b1;
    x_start_i = '0; y_start_i = '0; step_i = '0;
    width_i = '0; height_i = '0; max_iter_i = '0;
    lat[0] = 5; lat[1] = 5;
    repeat (3) @(negedge clk_i);
    chk("rst_core_rst", core_rst_o, 2'b11);
    chk("rst_core_start", core_start_o, 2'b00);
    chk("rst_valid", res_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_max_iter", core_max_iter_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // 2x2 frame, -2.0/-1.0 origin, 0.5 step
    sb = start_x.size(); rb = r_col.size(); db = done_cnt;
    drive_start(32'hFE000000, 32'hFF000000, 32'h00800000, 2, 2);
    chk("t1_first_start", core_start_o, 2'b01);
    chk("t1_first_x0", core_x0_o[0], 32'hFE000000);
    chk("t1_busy", busy_o, 1);
    chk("t1_max_iter", core_max_iter_o, 16'd100);
    wait_frame(db, "t1_done_once");
    exp_x = '{32'hFE000000, 32'hFE800000, 32'hFE000000, 32'hFE800000};
    exp_y = '{32'hFF000000, 32'hFF000000, 32'hFF800000, 32'hFF800000};
    for (int i = 0; i < 4; i++) begin
      if (sb + i < start_x.size()) begin
        chk("t1_hand_x0", start_x[sb+i], exp_x[i]);
        chk("t1_hand_y0", start_y[sb+i], exp_y[i]);
      end
    end
    check_frame(sb, rb, 32'hFE000000, 32'hFF000000, 32'h00800000, 2, 2, "t1");
    chk("t1_idle", busy_o, 0);

    // Unequal latencies: completion order differs from raster order
    lat[0] = 20; lat[1] = 3;
    sb = start_x.size(); rb = r_col.size(); db = done_cnt;
    s0 = starts_per[0]; s1 = starts_per[1]; q0 = rsts_per[0]; q1 = rsts_per[1];
    drive_start(32'h00000000, 32'h00000000, 32'h01000000, 3, 1);
    wait_frame(db, "t2_done_once");
    check_frame(sb, rb, 32'h00000000, 32'h00000000, 32'h01000000, 3, 1, "t2");
    if (r_col.size() >= rb + 3) begin
      chk("t2_order0", r_col[rb], 1);
      chk("t2_order1", r_col[rb+1], 2);
      chk("t2_order2", r_col[rb+2], 0);
    end
    chk("t2_rst_core0", rsts_per[0] - q0, starts_per[0] - s0);
    chk("t2_rst_core1", rsts_per[1] - q1, starts_per[1] - s1);
    chk("t2_rst_total", (rsts_per[0] - q0) + (rsts_per[1] - q1), 3);

    // Backpressure: both cores done while output is stalled
    lat[0] = 5; lat[1] = 5;
    res_ready_i = 1'b0;
    sb = start_x.size(); rb = r_col.size(); db = done_cnt; q1 = rsts_per[1];
    drive_start(32'h00100000, 32'h00200000, 32'h00010000, 2, 1);
    n = 0;
    while (!res_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("t3_valid", res_valid_o, 1);
    snap_col = res_col_o; snap_row = res_row_o; snap_iter = res_iter_o;
    unstable = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (!res_valid_o || res_col_o != snap_col || res_row_o != snap_row || res_iter_o != snap_iter)
        unstable++;
    end
    chk("t3_hold", unstable, 0);
    chk("t3_first_col", snap_col, 0);
    chk("t3_core1_waiting", rsts_per[1] - q1, 0);
`ifdef FRACTAL_DISPATCH_PERF_EN
    chk("t3_perf_stall", perf_stall_o != 0, 1);
`endif
    res_ready_i = 1'b1;
    wait_frame(db, "t3_done_once");
    check_frame(sb, rb, 32'h00100000, 32'h00200000, 32'h00010000, 2, 1, "t3");
    if (r_cyc.size() >= rb + 2) chk("t3_back_to_back", r_cyc[rb+1] - r_cyc[rb], 1);

    // Empty frame
    sb = start_x.size(); db = done_cnt;
    drive_start(32'h0, 32'h0, 32'h1, 0, 2);
    chk("t4_done", frame_done_o, 1);
    chk("t4_busy", busy_o, 1);
    chk("t4_no_start", core_start_o, 2'b00);
    @(negedge clk_i);
    chk("t4_done_clr", frame_done_o, 0);
    chk("t4_busy_clr", busy_o, 0);
    repeat (3) @(negedge clk_i);
    chk("t4_nstart", start_x.size() - sb, 0);
    chk("t4_done_cnt", done_cnt - db, 1);

    // Reset mid-frame, then a fresh frame
    lat[0] = 30; lat[1] = 30;
    db = done_cnt;
    drive_start(32'h12345678, 32'h0, 32'h1, 2, 2);
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t5_rst_core_rst", core_rst_o, 2'b11);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_valid", res_valid_o, 0);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    chk("t5_no_done", done_cnt - db, 0);
    lat[0] = 5; lat[1] = 5;
    sb = start_x.size(); rb = r_col.size(); db = done_cnt;
    drive_start(32'h00000000, 32'h01000000, 32'h00400000, 2, 2);
    wait_frame(db, "t5_done_once");
    check_frame(sb, rb, 32'h00000000, 32'h01000000, 32'h00400000, 2, 2, "t5");

    // start_i during RUN is ignored; x accumulator wraps
    lat[0] = 10; lat[1] = 10;
    sb = start_x.size(); rb = r_col.size(); db = done_cnt;
    drive_start(32'h7FFFFFFF, 32'h00000000, 32'h00000001, 3, 1);
    x_start_i = 32'h0; width_i = 12'd5; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_frame(db, "t6_done_once");
    check_frame(sb, rb, 32'h7FFFFFFF, 32'h00000000, 32'h00000001, 3, 1, "t6");
    if (start_x.size() >= sb + 3) begin
      chk("t6_wrap_x0", start_x[sb+1], 32'h80000000);
      chk("t6_wrap_x1", start_x[sb+2], 32'h80000001);
    end
    repeat (20) @(negedge clk_i);
    chk("t6_no_restart", done_cnt - db, 1);
    chk("t6_idle", busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fractal_dispatcher.md
Name: fractal_dispatcher

Overview:
- Frame-level scheduler for the fractal core array: walks a WIDTH x HEIGHT pixel grid and computes each pixel's c = x0 + i*y0 in Q(INTEGER_BITS).(FRACTIONAL_BITS).
- Issues each pixel to a free core and collects completed iteration counts.
- Streams results out tagged with pixel coordinates over a valid/ready interface.
- Sits between the frame-config register block and the core array; drives per-core reset/start.

Parameters:
- INTEGER_BITS, 8, integer bits of the fixed-point coordinate.
- FRACTIONAL_BITS, 24, fractional bits; DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS.
- MAX_ITER_WIDTH, 16, width of max_iter and the iteration result.
- CORE_COUNT, 2, number of cores managed (1..16).
- COORD_WIDTH, 12, width of pixel column/row counters and frame dimensions.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle frame start pulse; config inputs sampled on the same cycle.
- x_start_i  in  DATA_WIDTH  signed x0 of pixel (0,0).
- y_start_i  in  DATA_WIDTH  signed y0 of pixel (0,0).
- step_i  in  DATA_WIDTH  signed per-pixel increment, applied on both axes.
- width_i  in  COORD_WIDTH  columns per frame.
- height_i  in  COORD_WIDTH  rows per frame.
- max_iter_i  in  MAX_ITER_WIDTH  iteration limit; latched and driven to cores.
- core_rst_o  out  [CORE_COUNT] x 1  per-core reset.
- core_start_o  out  [CORE_COUNT] x 1  per-core start pulse.
- core_x0_o  out  [CORE_COUNT] x DATA_WIDTH  per-core x0; held stable while core runs.
- core_y0_o  out  [CORE_COUNT] x DATA_WIDTH  per-core y0; held stable while core runs.
- core_max_iter_o  out  MAX_ITER_WIDTH  latched max_iter.
- core_iter_i  in  [CORE_COUNT] x MAX_ITER_WIDTH  core result.
- core_done_i  in  [CORE_COUNT] x 1  core done level; held until the core is reset.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  consumer accepts the result.
- res_col_o  out  COORD_WIDTH  result pixel column.
- res_row_o  out  COORD_WIDTH  result pixel row.
- res_iter_o  out  MAX_ITER_WIDTH  result iteration count.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset: while rst_i=1, all outputs are 0 except core_rst_o, which is all 1s; all slots go FREE and the top FSM goes IDLE. Reset mid-frame abandons the frame; no frame_done_o pulse.
- Top FSM:
  - IDLE --start_i--> RUN. Config is latched; x_acc = x_start; y_acc = y_start; col = row = 0.
  - RUN --last pixel issued--> DRAIN --all slots FREE and no pending output--> DONE (frame_done_o=1 for one cycle) --> IDLE.
  - start_i outside IDLE is ignored.
  - width_i=0 or height_i=0: IDLE -> DONE -> IDLE. frame_done_o asserts 1 cycle after start_i; no dispatch.
- busy_o = 1 in RUN, DRAIN and DONE.
- Per-core slot states:
  - FREE: dispatch drives core_start_o[k]=1 for one cycle, sets core_x0/y0 = x_acc/y_acc, and stores tag (col,row). Goes to RUN.
  - RUN --core_done_i[k]--> DONE_W; iter is captured.
  - DONE_W --output handshake--> CLR.
  - CLR: core_rst_o[k]=1 for exactly one cycle, then FREE.
- Dispatch: at most one pixel per cycle, in RUN only, to the lowest-index FREE slot not in CLR. First core_start_o asserts the cycle after start_i.
- Pixel order is raster: col increments; at col = width-1, col returns to 0, row increments, x_acc reloads x_start and y_acc += step. Otherwise x_acc += step. Arithmetic is DATA_WIDTH two's-complement and wraps silently; no saturation.
- Output: single registered output stage.
  - When empty, it loads from DONE_W slots by round-robin, starting after the last granted index.
  - The granted slot moves to CLR on the load cycle.
  - Fields are held stable while res_valid_o=1 and res_ready_i=0. Transfer happens when valid and ready are both 1.
  - Refill is allowed on the same cycle as a transfer (full throughput).
  - Results are in completion order, not raster order.
- Simultaneous events: a slot can be granted for output and another slot dispatched on the same cycle. A slot in CLR is never dispatched on that cycle.
- frame_done_o asserts only after the last result has been transferred.

Optional Feature:
- Macro: FRACTAL_DISPATCH_PERF_EN.
- When defined:
  - Adds output perf_cycles_o (32 bits), which counts cycles from start_i acceptance to frame_done_o inclusive. It is held until the next accepted start_i and is cleared by rst_i.
  - Adds output perf_stall_o (32 bits), which counts cycles where a slot was in DONE_W but res_valid_o=1 and res_ready_i=0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- 2x2 frame, CORE_COUNT=2, stub cores done 5 cycles after start, res_ready_i=1, x_start=-2.0, y_start=-1.0, step=0.5 -> 4 results with (col,row,x0,y0) = (0,0,-2.0,-1.0), (1,0,-1.5,-1.0), (0,1,-2.0,-0.5), (1,1,-1.5,-0.5); frame_done_o pulses once after the 4th transfer.
- Stub core latencies 20/3 cycles, 1x3 frame -> col 1 result is output before col 0; each core gets exactly one core_rst_o pulse per result.
- res_ready_i=0 for 10 cycles with both cores done -> res_valid_o held with stable fields; second result is output the cycle after the first transfer; with FRACTAL_DISPATCH_PERF_EN, perf_stall_o > 0.
- width_i=0 -> frame_done_o 1 cycle after start_i, no core_start_o, busy_o high only for that cycle.
- rst_i asserted mid-frame, then a new start_i -> no frame_done_o for the abandoned frame; new frame completes with correct coordinates starting at (0,0).
- start_i pulsed during RUN -> ignored; pixel count and coordinates unchanged; x_start=0x7FFFFFFF with step=1 LSB -> next x0 wraps to 0x80000000.
